// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: data/instruction widths,
// instruction field positions, opcode values and the sequencer FSM encoding.
package alu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned NUM_REGS = 4;

  // Instruction field LSB positions; imm8 overlays rb and the low bits.
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RA_LSB  = 8;
  localparam int unsigned RB_LSB  = 6;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_PASSB = 4'h0;
  localparam logic [OP_W-1:0] OP_NOT   = 4'h1;
  localparam logic [OP_W-1:0] OP_AND   = 4'h2;
  localparam logic [OP_W-1:0] OP_OR    = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
  localparam logic [OP_W-1:0] OP_SHL   = 4'h7;
  localparam logic [OP_W-1:0] OP_SHR   = 4'h8;
  localparam logic [OP_W-1:0] OP_SRA   = 4'h9;
  localparam logic [OP_W-1:0] OP_LDI   = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] iw);
    return iw[OP_LSB +: OP_W];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rd(input logic [INSTR_W-1:0] iw);
    return iw[RD_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] instr_ra(input logic [INSTR_W-1:0] iw);
    return iw[RA_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rb(input logic [INSTR_W-1:0] iw);
    return iw[RB_LSB +: REG_AW];
  endfunction

  function automatic logic [DATA_W-1:0] instr_imm(input logic [INSTR_W-1:0] iw);
    return iw[IMM_LSB +: DATA_W];
  endfunction

  // True for opcodes with an ALU-defined meaning; others pass through verbatim.
  function automatic logic op_is_defined(input logic [OP_W-1:0] op);
    return (op == OP_PASSB) || (op == OP_NOT) || (op == OP_AND) ||
           (op == OP_OR)    || (op == OP_XOR) || (op == OP_SHL) ||
           (op == OP_SHR)   || (op == OP_SRA) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// 4-entry x 8-bit register file.
// Ports: clk, rst (sync, active-high, clears all entries); we/waddr/wdata
// synchronous write; raddr_a/rdata_a and raddr_b/rdata_b combinational
// operand reads; dbg_addr/dbg_data combinational debug read.
module regfile4x8
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the external combinational 8-bit ALU.
// Accepts one 16-bit instruction per valid/ready handshake, reads operands
// from a 4x8 register file, drives registered alu_sel/alu_a/alu_b, waits
// EXEC_WAIT cycles for alu_c to settle, then writes the result back.
// Ports: clk, rst (sync, active-high); instr/instr_valid/instr_ready fetch
// handshake; alu_sel/alu_a/alu_b ALU drive, alu_c ALU result; done one-cycle
// write-back pulse; dbg_addr/dbg_data combinational register-file peek.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned EXEC_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [OP_W-1:0]    alu_sel,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_c,
  output logic               done,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int unsigned CNT_W = 2;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [REG_AW-1:0]   rd_sel, rd_sel_next;
  logic [DATA_W-1:0]   result, result_next;
  logic [OP_W-1:0]     alu_sel_next;
  logic [DATA_W-1:0]   alu_a_next, alu_b_next;
  logic                done_next;

  logic [DATA_W-1:0]   rdata_a, rdata_b;
  logic                rf_we;

  // Ready depends only on state and reset, never on instr_valid.
  assign instr_ready = (state == IDLE) && !rst;
  assign rf_we       = (state == WB);

  regfile4x8 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd_sel),
    .wdata    (result),
    .raddr_a  (instr_ra(instr)),
    .rdata_a  (rdata_a),
    .raddr_b  (instr_rb(instr)),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_sel  <= '0;
      result  <= '0;
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      rd_sel  <= rd_sel_next;
      result  <= result_next;
      alu_sel <= alu_sel_next;
      alu_a   <= alu_a_next;
      alu_b   <= alu_b_next;
      done    <= done_next;
    end
  end

  // Next-state and datapath update. done is raised on entry to WB so the
  // registered pulse coincides with the WB cycle.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    rd_sel_next  = rd_sel;
    result_next  = result;
    alu_sel_next = alu_sel;
    alu_a_next   = alu_a;
    alu_b_next   = alu_b;
    done_next    = 1'b0;

    unique case (state)
      IDLE: begin
        if (instr_valid) begin
          rd_sel_next = instr_rd(instr);
          if (instr_op(instr) == OP_LDI) begin
            // ALU drive holds its previous values for LDI.
            result_next = instr_imm(instr);
            state_next  = WB;
            done_next   = 1'b1;
          end else begin
            // Operands captured at accept, so rd may alias ra/rb safely.
            alu_sel_next = instr_op(instr);
            alu_a_next   = rdata_a;
            alu_b_next   = rdata_b;
            cnt_next     = CNT_W'(EXEC_WAIT - 1);
            state_next   = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          result_next = alu_c;
          state_next  = WB;
          done_next   = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: two instances (EXEC_WAIT=1 and 4)
// each driving a behavioural stand-in for ALU8bit.
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic [1:0]  dbg_addr;
  logic        which;

  logic        valid1, valid4;
  logic        ready1, ready4, done1, done4;
  logic [3:0]  sel1, sel4;
  logic [7:0]  a1, b1, c1, a4, b4, c4, dbg1, dbg4;
  logic        ready_m, done_m;
  logic [3:0]  sel_m;
  logic [7:0]  a_m, b_m, dbg_m;

  typedef struct packed { logic [1:0] rd; logic [7:0] val; } sb_t;
  typedef struct { logic [15:0] iw; logic [1:0] chk; logic [7:0] exp; } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   acc_cyc = 0;
  int   done_cyc[$];
  sb_t  sb[$];
  sb_t  retired[$];
  sb_t  mon_e;
  logic [7:0] model_r [4];
  vec_t vecs [16];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU8bit.
  function automatic logic [7:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      4'h0:    return b;
      4'h1:    return ~b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h7:    return a << b;
      4'h8:    return a >> b;
      4'h9:    return 8'($signed(a) >>> b);
      default: return a + b;
    endcase
  endfunction

  assign c1 = alu_f(sel1, a1, b1);
  assign c4 = alu_f(sel4, a4, b4);
  assign valid1 = instr_valid & ~which;
  assign valid4 = instr_valid & which;
  assign ready_m = which ? ready4 : ready1;
  assign done_m  = which ? done4  : done1;
  assign sel_m   = which ? sel4   : sel1;
  assign a_m     = which ? a4     : a1;
  assign b_m     = which ? b4     : b1;
  assign dbg_m   = which ? dbg4   : dbg1;

  alu_sequencer #(.EXEC_WAIT(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(valid1), .instr_ready(ready1),
    .alu_sel(sel1), .alu_a(a1), .alu_b(b1), .alu_c(c1), .done(done1),
    .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  alu_sequencer #(.EXEC_WAIT(4)) dut4 (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(valid4), .instr_ready(ready4),
    .alu_sel(sel4), .alu_a(a4), .alu_b(b4), .alu_c(c4), .done(done4),
    .dbg_addr(dbg_addr), .dbg_data(dbg4)
  );

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 6'b0};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {OP_LDI, rd, 2'b00, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(name, 32'(dbg_m), 32'(exp));
  endtask

  // Scoreboard retire: pop the expected write-back on each done pulse.
  always @(negedge clk) begin
    if (done_m === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: actual done=1 required no pending instruction (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        model_r[mon_e.rd] = mon_e.val;
        retired.push_back(mon_e);
      end
    end
  end

  // Present iw with valid high until accepted; expected result pushed at accept.
  task automatic issue(input logic [15:0] iw);
    int  n = 0;
    sb_t e;
    @(negedge clk);
    instr = iw;
    instr_valid = 1'b1;
    #1;
    while (!ready_m && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ready_m) begin
      check("accept_timeout", 32'(ready_m), 32'd1);
      return;
    end
    e.rd = iw[11:10];
    if (iw[15:12] == OP_LDI) e.val = iw[7:0];
    else e.val = alu_f(iw[15:12], model_r[iw[9:8]], model_r[iw[7:6]]);
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  // Drop valid, wait for all outstanding work, then verify retired writes.
  task automatic drain();
    int  n = 0;
    sb_t e;
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    while (!(sb.size() == 0 && ready_m) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!(sb.size() == 0 && ready_m)) check("drain_timeout", 32'(sb.size()), 32'd0);
    while (retired.size() > 0) begin
      e = retired.pop_front();
      check_reg($sformatf("sb_rd%0d", e.rd), e.rd, e.val);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    retired.delete();
    for (int i = 0; i < 4; i++) model_r[i] = 8'h00;
  endtask

  task automatic burst(input int gap, input string tag);
    int c0;
    issue(ldi(2'd0, 8'h3C)); drain();
    issue(ldi(2'd1, 8'h0F)); drain();
    done_cyc.delete();
    c0 = done_cnt;
    issue(enc(OP_AND, 2'd2, 2'd0, 2'd1));
    issue(enc(OP_OR,  2'd3, 2'd0, 2'd1));
    issue(enc(OP_XOR, 2'd0, 2'd0, 2'd1));
    issue(enc(OP_NOT, 2'd1, 2'd0, 2'd1));
    drain();
    check({tag, "_done_count"}, 32'(done_cnt - c0), 32'd4);
    if (done_cyc.size() == 4) begin
      for (int k = 1; k < 4; k++)
        check($sformatf("%s_spacing%0d", tag, k), 32'(done_cyc[k] - done_cyc[k-1]), 32'(gap));
    end
    check_reg({tag, "_r0"}, 2'd0, 8'h33);
    check_reg({tag, "_r1"}, 2'd1, 8'hF0);
    check_reg({tag, "_r2"}, 2'd2, 8'h0C);
    check_reg({tag, "_r3"}, 2'd3, 8'h3F);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; instr = '0; instr_valid = 1'b0; dbg_addr = '0; which = 1'b0;
    clear_model();

    vecs[0]  = '{ldi(2'd1, 8'hF3), 2'd1, 8'hF3};
    vecs[1]  = '{ldi(2'd2, 8'h25), 2'd2, 8'h25};
    vecs[2]  = '{enc(OP_AND, 2'd3, 2'd1, 2'd2), 2'd3, 8'h21};
    vecs[3]  = '{ldi(2'd0, 8'hA3), 2'd0, 8'hA3};
    vecs[4]  = '{ldi(2'd1, 8'h02), 2'd1, 8'h02};
    vecs[5]  = '{enc(OP_SHL, 2'd2, 2'd0, 2'd1), 2'd2, 8'h8C};
    vecs[6]  = '{enc(OP_SHR, 2'd2, 2'd0, 2'd1), 2'd2, 8'h28};
    vecs[7]  = '{enc(OP_SRA, 2'd2, 2'd0, 2'd1), 2'd2, 8'hE8};
    vecs[8]  = '{enc(OP_XOR, 2'd0, 2'd0, 2'd0), 2'd0, 8'h00};
    vecs[9]  = '{ldi(2'd2, 8'h0C), 2'd2, 8'h0C};
    vecs[10] = '{enc(OP_NOT, 2'd1, 2'd0, 2'd2), 2'd1, 8'hF3};
    vecs[11] = '{enc(OP_PASSB, 2'd1, 2'd0, 2'd2), 2'd1, 8'h0C};
    vecs[12] = '{ldi(2'd3, 8'h09), 2'd3, 8'h09};
    vecs[13] = '{ldi(2'd0, 8'h80), 2'd0, 8'h80};
    vecs[14] = '{enc(OP_SRA, 2'd1, 2'd0, 2'd3), 2'd1, 8'hFF};
    vecs[15] = '{enc(OP_SHL, 2'd2, 2'd0, 2'd3), 2'd2, 8'h00};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("ready_during_reset", 32'(ready_m), 32'd0);
    check("done_reset", 32'(done_m), 32'd0);
    check("alu_sel_reset", 32'(sel_m), 32'd0);
    check("alu_a_reset", 32'(a_m), 32'd0);
    check("alu_b_reset", 32'(b_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(ready_m), 32'd1);
    for (int r = 0; r < 4; r++) check_reg($sformatf("reset_r%0d", r), 2'(r), 8'h00);

    // Table vectors, EXEC_WAIT=1.
    for (int i = 0; i < 3; i++) begin
      issue(vecs[i].iw);
      drain();
      check_reg($sformatf("vec%0d", i), vecs[i].chk, vecs[i].exp);
    end
    check("and_latency", 32'(done_cyc[done_cyc.size()-1] - acc_cyc), 32'd1);
    check("done_per_instr", 32'(done_cnt), 32'd3);
    for (int i = 3; i < 16; i++) begin
      issue(vecs[i].iw);
      drain();
      check_reg($sformatf("vec%0d", i), vecs[i].chk, vecs[i].exp);
      if (i == 3) begin
        check("ldi_holds_sel", 32'(sel_m), 32'h2);
        check("ldi_holds_a", 32'(a_m), 32'hF3);
        check("ldi_holds_b", 32'(b_m), 32'h25);
      end
    end
    check("done_total", 32'(done_cnt), 32'd16);

    // Reset during EXEC aborts the OR.
    issue(ldi(2'd1, 8'h73)); drain();
    issue(ldi(2'd2, 8'h8B)); drain();
    issue(ldi(2'd3, 8'h55)); drain();
    c0 = done_cnt;
    issue(enc(OP_OR, 2'd3, 2'd1, 2'd2));
    check("or_alu_a", 32'(a_m), 32'h73);
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    #1;
    check("ready_in_rst_a", 32'(ready_m), 32'd0);
    @(negedge clk);
    #1;
    check("ready_in_rst_b", 32'(ready_m), 32'd0);
    rst = 1'b0;
    clear_model();
    #1;
    check("ready_after_rst", 32'(ready_m), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("no_done_after_abort", 32'(done_cnt - c0), 32'd0);
    check("alu_sel_after_abort", 32'(sel_m), 32'd0);
    for (int r = 0; r < 4; r++) check_reg($sformatf("abort_r%0d", r), 2'(r), 8'h00);

    // Back-to-back bursts.
    burst(3, "b2b_w1");
    @(negedge clk);
    which = 1'b1;
    clear_model();
    issue(enc(OP_PASSB, 2'd0, 2'd0, 2'd0));
    drain();
    check("w4_latency", 32'(done_cyc[done_cyc.size()-1] - acc_cyc), 32'd4);
    burst(6, "b2b_w4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Drives the 8-bit ALU from a stream of 16-bit instructions. It accepts one instruction per valid/ready handshake and decodes it into ALU select and operand fields from a 4-entry, 8-bit register file. It then drives the ALU inputs, waits for the ALU to settle, and writes the ALU result back. It sits between the fetch stage and the existing combinational ALU8bit, and is the initiator of the ALU's sel/A/B to C interface.

## Interface
- EXEC_WAIT, default 1: ALU settle cycles spent in EXEC; legal range 1..4.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr  in  16  instruction word: [15:12] op, [11:10] rd, [9:8] ra, [7:6] rb, [7:0] imm8 (LDI only).
- instr_valid  in  1  instr is presented.
- instr_ready  out  1  sequencer can accept; equals (state==IDLE) & ~rst.
- alu_sel  out  4  ALU select, registered.
- alu_a  out  8  ALU operand A, registered.
- alu_b  out  8  ALU operand B, registered.
- alu_c  in  8  ALU result, combinational from ALU8bit.
- done  out  1  one-cycle pulse when the write-back occurs.
- dbg_addr  in  2  debug register-read address.
- dbg_data  out  8  register file[dbg_addr], combinational.

## Operation
- Opcodes 0000..1110 are ALU ops. alu_sel = op.
  - Defined codes: 0000 pass B, 0001 NOT B, 0010 AND, 0011 OR, 0100 XOR, 0111 SHL, 1000 SHR, 1001 SRA.
  - Other codes are forwarded verbatim; the result is whatever the ALU returns.
- Opcode 1111 is LDI: rd = imm8. The ALU is not used, and alu_* hold their previous values.
- FSM states are IDLE, EXEC and WB.
- IDLE:
  - Handshake fires when instr_valid & instr_ready.
  - ALU op: latch alu_sel=op, alu_a=R[ra], alu_b=R[rb] and rd; load the wait counter to EXEC_WAIT-1; go to EXEC.
  - LDI: latch imm8 and rd; go to WB.
- EXEC: the counter decrements each cycle. At counter==0, capture alu_c into the result register and go to WB.
- WB: R[rd] = result; done=1; go to IDLE.
- Operands are read at accept, so rd may equal ra and/or rb. The sources use pre-write values.
- Shift amount is the full 8-bit alu_b; the ALU defines behaviour for values ≥8.
- instr_valid while not ready: not accepted and no state change. The source must hold instr stable until accepted.
- Reset:
  - Registers R0..R3 reset to 0x00; alu_sel, alu_a and alu_b reset to 0; done resets to 0; state resets to IDLE.
  - instr_ready is 0 while rst=1.
  - Reset mid-operation aborts the instruction: no write-back and no done pulse.

## Timing
- Accept at edge N (ALU op). alu_sel, alu_a and alu_b are valid from N through the end of EXEC.
- EXEC occupies EXEC_WAIT cycles. alu_c is sampled at the last EXEC edge, N+EXEC_WAIT.
- WB edge is N+EXEC_WAIT+1:
  - The register write is visible on dbg_data after this edge.
  - done is high during the WB cycle, i.e. between edges N+EXEC_WAIT and N+EXEC_WAIT+1.
- instr_ready is high again in the cycle after WB.
- Throughput:
  - ALU op: one instruction per EXEC_WAIT+2 cycles.
  - LDI: one instruction per 2 cycles (IDLE, WB).
- dbg_data reading R[rd] during the WB cycle shows the old value; it shows the new value from the next cycle.
- No combinational path from instr_valid to instr_ready.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: OP_PASSB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SRA, OP_LDI=4'hF;
  - instruction field bit positions;
  - the FSM state encoding.
- Sub-module regfile4x8: two combinational read ports plus the debug read port, one synchronous write port, and synchronous reset to 0.
- ALU8bit is instantiated by the enclosing datapath, not inside this block. The bench instantiates it directly.

## Test plan
- LDI r1,0xF3; LDI r2,0x25; AND r3=r1&r2:
  - done pulses once per instruction;
  - dbg_addr=3 gives 0x21;
  - AND sequence is IDLE, EXEC, WB with EXEC_WAIT=1.
- LDI r0,0xA3; LDI r1,0x02:
  - SHL r2=r0<<r1 gives 0x8C;
  - SHR r2 gives 0x28;
  - SRA r2 gives 0xE8.
- XOR r0=r0^r0 after LDI r0,0xA3: r0 becomes 0x00, showing operand capture before write.
- Back-to-back valid held high for 4 ALU ops:
  - exactly 4 done pulses, each 3 cycles apart (EXEC_WAIT=1);
  - with EXEC_WAIT=4, 6 cycles apart;
  - no instruction is lost or duplicated.
- Reset during EXEC of OR r3=r1|r2 (r1=0x73, r2=0x8B, r3=0x55):
  - no done pulse;
  - all registers read 0x00 afterwards;
  - instr_ready=0 while rst is high, then 1.
- NOT r1=~r2 with r2=0x0C gives 0xF3. Pass-B r1=r2 with r2=0x0C gives 0x0C.
